// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter for the common data bus.
// Functional units hold a finished result with valid high. One unit is granted
// per cycle. Its {rob_ix, value} is broadcast on a registered CDB, and a one-cycle
// read pulse is returned to it. A unit whose read pulse is live is masked
// from the search, so the same result is never broadcast twice.
module cdb_arbiter #(
  parameter  int N        = 4,
  parameter  int ROB_IX_W = 3,
  parameter  int DATA_W   = 32,
  parameter  int CNT_W    = 16,
  localparam int SRC_W    = $clog2(N)
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic [N-1:0]                     valid_in,
  input  logic [N-1:0][ROB_IX_W-1:0]       rob_ix_in,
  input  logic [N-1:0][DATA_W-1:0]         value_in,
  output logic [N-1:0]                     read_out,
  output logic                             cdb_valid_out,
  output logic [ROB_IX_W-1:0]              cdb_rob_ix_out,
  output logic [DATA_W-1:0]                cdb_value_out,
  output logic [SRC_W-1:0]                 cdb_src_out,
  output logic [CNT_W-1:0]                 conflict_cnt_out
);

  logic [SRC_W-1:0]    r_ptr;
  logic [N-1:0]        r_read;
  logic                r_cdb_valid;
  logic [ROB_IX_W-1:0] r_cdb_rob_ix;
  logic [DATA_W-1:0]   r_cdb_value;
  logic [SRC_W-1:0]    r_cdb_src;
  logic [CNT_W-1:0]    r_conflict_cnt;

  logic [N-1:0]        w_elig;
  logic                w_found;
  logic [SRC_W-1:0]    w_gnt;
  logic [SRC_W:0]      w_pop;
  logic                w_multi;
  logic [SRC_W-1:0]    w_ptr_nxt;

  // Round-robin search starting at r_ptr, wrapping modulo N (N need not be a power of 2)
  always_comb begin
    int v_sum;
    w_elig  = valid_in & ~r_read;
    w_found = 1'b0;
    w_gnt   = '0;
    v_sum   = 0;
    for (int k = 0; k < N; k++) begin
      v_sum = int'(r_ptr) + k;
      v_sum = (v_sum >= N) ? (v_sum - N) : v_sum;
      if (!w_found && w_elig[v_sum[SRC_W-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = v_sum[SRC_W-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

  // Count eligible requesters to detect contention, and form the next pointer
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N; i++) begin
      w_pop = w_pop + {{SRC_W{1'b0}}, w_elig[i]};
    end
    w_multi   = (w_pop >= (SRC_W+1)'(2));
    w_ptr_nxt = (w_gnt == SRC_W'(N-1)) ? '0 : (w_gnt + SRC_W'(1));
  end

  // Registered CDB broadcast, read pulse, pointer and saturating contention counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_ptr          <= '0;
      r_read         <= '0;
      r_cdb_valid    <= 1'b0;
      r_cdb_rob_ix   <= '0;
      r_cdb_value    <= '0;
      r_cdb_src      <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_multi && (r_conflict_cnt != {CNT_W{1'b1}})) begin
        r_conflict_cnt <= r_conflict_cnt + CNT_W'(1);
      end
      if (w_found) begin
        r_cdb_valid  <= 1'b1;
        r_cdb_rob_ix <= rob_ix_in[w_gnt];
        r_cdb_value  <= value_in[w_gnt];
        r_cdb_src    <= w_gnt;
        r_read       <= N'(1) << w_gnt;
        r_ptr        <= w_ptr_nxt;
      end else begin
        r_cdb_valid  <= 1'b0;
        r_read       <= '0;
      end
    end
  end

  assign read_out         = r_read;
  assign cdb_valid_out    = r_cdb_valid;
  assign cdb_rob_ix_out   = r_cdb_rob_ix;
  assign cdb_value_out    = r_cdb_value;
  assign cdb_src_out      = r_cdb_src;
  assign conflict_cnt_out = r_conflict_cnt;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for cdb_arbiter (N=4 main instance, N=3 wrap instance).
module tb_cdb_arbiter;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [3:0]       valid_in;
  logic [3:0][2:0]  rob_ix_in;
  logic [3:0][31:0] value_in;
  logic [3:0]       read_out;
  logic             cdb_valid_out;
  logic [2:0]       cdb_rob_ix_out;
  logic [31:0]      cdb_value_out;
  logic [1:0]       cdb_src_out;
  logic [15:0]      conflict_cnt_out;

  logic [2:0]       v3;
  logic [2:0][2:0]  rob3;
  logic [2:0][31:0] val3;
  logic [2:0]       read3;
  logic             cv3;
  logic [2:0]       crob3;
  logic [31:0]      cval3;
  logic [1:0]       src3;
  logic [15:0]      cnt3;

  always #5 clk_in = ~clk_in;

  cdb_arbiter #(.N(4), .ROB_IX_W(3), .DATA_W(32), .CNT_W(16)) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(valid_in), .rob_ix_in(rob_ix_in),
    .value_in(value_in), .read_out(read_out), .cdb_valid_out(cdb_valid_out),
    .cdb_rob_ix_out(cdb_rob_ix_out), .cdb_value_out(cdb_value_out),
    .cdb_src_out(cdb_src_out), .conflict_cnt_out(conflict_cnt_out)
  );

  cdb_arbiter #(.N(3), .ROB_IX_W(3), .DATA_W(32), .CNT_W(16)) u_dut3 (
    .clk_in(clk_in), .rst_in(rst_in), .valid_in(v3), .rob_ix_in(rob3),
    .value_in(val3), .read_out(read3), .cdb_valid_out(cv3),
    .cdb_rob_ix_out(crob3), .cdb_value_out(cval3),
    .cdb_src_out(src3), .conflict_cnt_out(cnt3)
  );

  typedef struct packed {
    logic        v;
    logic [2:0]  rob;
    logic [31:0] val;
    logic [1:0]  src;
    logic [3:0]  rd;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  // functional-unit models: per-unit result store, valid flag, idle countdown
  logic [34:0] fmem [4][16];
  int          fwr [4];
  int          frd [4];
  int          f_idle [4];
  logic [3:0]  f_valid;
  logic [3:0]  prev_rd;
  int          gap_cfg;

  // reference model state
  int          m_ptr;
  logic [3:0]  m_read;
  logic        m_v;
  logic [2:0]  m_rob;
  logic [31:0] m_val;
  int          m_src;
  logic [15:0] m_cnt;

  // broadcast log
  int          log_src[$];
  logic [2:0]  log_rob[$];
  logic [31:0] log_val[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_item(input int i, input logic [2:0] rob, input logic [31:0] val);
    fmem[i][fwr[i]] = {rob, val};
    fwr[i]++;
  endtask

  task automatic clear_log();
    log_src.delete();
    log_rob.delete();
    log_val.delete();
  endtask

  // One cycle: check outputs of the last edge, react as FUs, predict next edge, advance.
  task automatic step();
    exp_t       e;
    logic [3:0] elig;
    int         g;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_val("cdb_valid", 64'(cdb_valid_out), 64'(e.v));
      check_val("cdb_rob_ix", 64'(cdb_rob_ix_out), 64'(e.rob));
      check_val("cdb_value", 64'(cdb_value_out), 64'(e.val));
      check_val("cdb_src", 64'(cdb_src_out), 64'(e.src));
      check_val("read_out", 64'(read_out), 64'(e.rd));
      check_val("conflict_cnt", 64'(conflict_cnt_out), 64'(e.cnt));
      if (cdb_valid_out) begin
        log_src.push_back(int'(cdb_src_out));
        log_rob.push_back(cdb_rob_ix_out);
        log_val.push_back(cdb_value_out);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (f_valid[i] && prev_rd[i]) begin
        f_valid[i] = 1'b0;
        f_idle[i]  = gap_cfg;
      end
      if (!f_valid[i]) begin
        if (f_idle[i] > 0) begin
          f_idle[i]--;
        end else if (frd[i] < fwr[i]) begin
          f_valid[i] = 1'b1;
          {rob_ix_in[i], value_in[i]} = fmem[i][frd[i]];
          frd[i]++;
        end
      end
    end
    prev_rd  = read_out;
    valid_in = f_valid;
    if (rst_in) begin
      m_ptr = 0; m_read = 4'b0000; m_v = 1'b0; m_rob = 3'd0;
      m_val = 32'd0; m_src = 0; m_cnt = 16'd0;
    end else begin
      elig = valid_in & ~m_read;
      g    = -1;
      for (int k = 0; k < 4; k++) begin
        if (g < 0 && elig[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      if ($countones(elig) >= 2 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      if (g >= 0) begin
        m_v    = 1'b1;
        m_rob  = rob_ix_in[g];
        m_val  = value_in[g];
        m_src  = g;
        m_read = 4'b0001 << g;
        m_ptr  = (g + 1) % 4;
      end else begin
        m_v    = 1'b0;
        m_read = 4'b0000;
      end
    end
    e = '{v: m_v, rob: m_rob, val: m_val, src: 2'(m_src), rd: m_read, cnt: m_cnt};
    sb.push_back(e);
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
  endtask

  initial begin
    int exp3 [5] = '{0, 1, 2, 0, 1};
    rst_in    = 1'b1;
    valid_in  = 4'b0000;
    rob_ix_in = '0;
    value_in  = '0;
    v3        = 3'b000;
    rob3      = '0;
    val3      = '0;
    f_valid   = 4'b0000;
    prev_rd   = 4'b0000;
    gap_cfg   = 1;
    m_ptr = 0; m_read = 4'b0000; m_v = 1'b0; m_rob = 3'd0;
    m_val = 32'd0; m_src = 0; m_cnt = 16'd0;
    for (int i = 0; i < 4; i++) begin
      fwr[i] = 0; frd[i] = 0; f_idle[i] = 0;
    end

    // reset with no requests: everything zero
    step();
    step();
    check_val("rst_valid", 64'(cdb_valid_out), 64'd0);
    check_val("rst_read", 64'(read_out), 64'd0);
    check_val("rst_rob", 64'(cdb_rob_ix_out), 64'd0);
    check_val("rst_value", 64'(cdb_value_out), 64'd0);
    check_val("rst_src", 64'(cdb_src_out), 64'd0);
    check_val("rst_cnt", 64'(conflict_cnt_out), 64'd0);
    rst_in = 1'b0;
    repeat (2) step();

    // single request from FU0: exactly one broadcast
    clear_log();
    push_item(0, 3'd5, 32'h0000_1234);
    repeat (6) step();
    check_val("single_count", 64'(log_src.size()), 64'd1);
    if (log_src.size() > 0) begin
      check_val("single_src", 64'(log_src[0]), 64'd0);
      check_val("single_rob", 64'(log_rob[0]), 64'd5);
      check_val("single_val", 64'(log_val[0]), 64'h1234);
    end

    // all four busy, drop after read, re-raise one cycle later
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) push_item(i, 3'(i * 2 + k), $urandom);
    end
    repeat (14) step();
    check_val("rr_count", 64'(log_src.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < log_src.size()) check_val("rr_order", 64'(log_src[k]), 64'(k % 4));
    end

    // pointer at 3 with FU0 and FU3 requesting: grant 3 then wrap to 0
    do_reset();
    clear_log();
    push_item(2, 3'd2, 32'hAAAA_0002);
    repeat (4) step();
    push_item(0, 3'd0, 32'hBBBB_0000);
    push_item(3, 3'd3, 32'hBBBB_0003);
    repeat (5) step();
    push_item(0, 3'd4, 32'hCCCC_0000);
    push_item(1, 3'd1, 32'hCCCC_0001);
    repeat (5) step();
    check_val("wrap_count", 64'(log_src.size()), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < log_src.size()) check_val("wrap_order", 64'(log_src[k]), 64'(k == 0 ? 2 : k == 1 ? 3 : k == 2 ? 0 : k == 3 ? 1 : 0));
    end

    // reset while the CDB is busy; pending units re-arbitrate from 0
    do_reset();
    clear_log();
    for (int i = 0; i < 4; i++) push_item(i, 3'(7 - i), 32'hD000_0000 + i);
    repeat (2) step();
    check_val("mid_busy", 64'(cdb_valid_out), 64'd1);
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    check_val("mid_valid", 64'(cdb_valid_out), 64'd0);
    check_val("mid_read", 64'(read_out), 64'd0);
    check_val("mid_rob", 64'(cdb_rob_ix_out), 64'd0);
    check_val("mid_value", 64'(cdb_value_out), 64'd0);
    check_val("mid_src", 64'(cdb_src_out), 64'd0);
    check_val("mid_cnt", 64'(conflict_cnt_out), 64'd0);
    repeat (8) step();
    check_val("mid_count", 64'(log_src.size()), 64'd4);
    for (int k = 0; k < 4; k++) begin
      if (k < log_src.size()) check_val("mid_order", 64'(log_src[k]), 64'(k));
    end

    // N=3 instance, all units held valid: order 0,1,2,0,1
    do_reset();
    v3   = 3'b111;
    rob3 = {3'd2, 3'd1, 3'd0};
    val3 = {32'h3333_0002, 32'h3333_0001, 32'h3333_0000};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk_in);
      #1;
      check_val("n3_valid", 64'(cv3), 64'd1);
      check_val("n3_src", 64'(src3), 64'(exp3[k]));
    end
    check_val("n3_read", 64'(read3), 64'b010);
    check_val("n3_rob", 64'(crob3), 64'd1);
    check_val("n3_cnt", 64'(cnt3), 64'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
